usart_fifo_link: RTL

Parametrised single-channel USART transceiver, successor to the fixed 8-bit transmitter/receiver pair. Adds configurable data width, TX/RX FIFOs, a runtime baud divider, optional parity, 1/2 stop bits, an internal loopback mode replacing the external pair wiring, and sticky error status. Sits between the CPU bus (CPU_Clk domain) and the serial line SLBit.

---
 rtl/usart_fifo_link_if.sv | 38 +++
 rtl/usart_fifo_link.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_fifo_link_if.sv
// usart_fifo_link_if: CPU-side bus and serial-line bundle for usart_fifo_link.
//   master : driver side (CPU / bench) - pushes TX data, pops RX data,
//            sets configuration, drives SLBit_in.
//   slave  : the transceiver itself.
interface usart_fifo_link_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic              Wr_En;
    logic [DATA_W-1:0] CPU_Data_in;
    logic              Rd_En;
    logic [DATA_W-1:0] CPU_Data_out;
    logic [3:0]        Control;
    logic [DIV_W-1:0]  Baud_Div;
    logic              Clr_Err;
    logic              SLBit_in;
    logic              SLBit_out;
    logic              Tx_Full;
    logic              Tx_Empty;
    logic              Rx_Full;
    logic              Rx_Empty;
    logic              Tx_Busy;
    logic              Parity_Err;
    logic              Frame_Err;
    logic              Overrun;

    modport master (
        output Wr_En, CPU_Data_in, Rd_En, Control, Baud_Div, Clr_Err, SLBit_in,
        input  CPU_Data_out, SLBit_out, Tx_Full, Tx_Empty, Rx_Full, Rx_Empty,
               Tx_Busy, Parity_Err, Frame_Err, Overrun
    );

    modport slave (
        input  Wr_En, CPU_Data_in, Rd_En, Control, Baud_Div, Clr_Err, SLBit_in,
        output CPU_Data_out, SLBit_out, Tx_Full, Tx_Empty, Rx_Full, Rx_Empty,
               Tx_Busy, Parity_Err, Frame_Err, Overrun
    );
endinterface

// File: rtl/usart_fifo_link.sv
// usart_fifo_link: single-channel USART with TX/RX FIFOs, runtime baud divider,
// optional parity, 1/2 stop bits, internal loopback and sticky error flags.
//   CPU_Clk : sole clock
//   Reset   : asynchronous, active-low
//   bus     : usart_fifo_link_if.slave (CPU push/pop, Control, Baud_Div,
//             Clr_Err, serial line in/out, FIFO status, error flags)
//
// State | meaning (shared by the TX and RX FSMs)
//   S_IDLE   | line idle; TX waits for FIFO data, RX waits for a falling edge
//   S_START  | start bit (RX: half-period check for false start)
//   S_DATA   | DATA_W data bits, LSB first
//   S_PARITY | parity bit, only when enabled for the frame
//   S_STOP   | stop bit(s); RX samples only the first one
module usart_fifo_link #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic              CPU_Clk,
    input  logic              Reset,
    usart_fifo_link_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(3);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Divider clamp: at least 4 clocks per bit so the RX mid-bit sampling works.
    logic [DIV_W-1:0] div_eff;
    assign div_eff = (bus.Baud_Div < MIN_DIV) ? MIN_DIV : bus.Baud_Div;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr;
    logic [CNT_W-1:0]  tx_count, tx_count_nxt;
    logic              tx_full, tx_empty;
    logic              tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;
    state_t            tx_state;

    assign tx_push = bus.Wr_En && !tx_full;
    assign tx_pop  = (tx_state == S_IDLE) && !tx_empty;
    assign tx_head = tx_mem[tx_rd_ptr];

    always_comb begin
        tx_count_nxt = tx_count;
        if (tx_push && !tx_pop)
            tx_count_nxt = tx_count + 1'b1;
        else if (!tx_push && tx_pop)
            tx_count_nxt = tx_count - 1'b1;
    end

    always_ff @(posedge CPU_Clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= bus.CPU_Data_in;
    end

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_full   <= 1'b0;
            tx_empty  <= 1'b1;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count_nxt;
            tx_full  <= (tx_count_nxt == FULL_CNT);
            tx_empty <= (tx_count_nxt == '0);
        end
    end

    // ---------------- TX FSM ----------------
    logic [DIV_W-1:0]  tx_cnt, tx_div;
    logic [IDX_W-1:0]  tx_bit;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_line, tx_busy;
    logic              tx_par_en, tx_par_bit, tx_two_stop, tx_stop2;

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_div      <= '0;
            tx_bit      <= '0;
            tx_sh       <= '0;
            tx_line     <= 1'b1;
            tx_busy     <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_stop2    <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    if (!tx_empty) begin
                        // Frame configuration is frozen here for the whole frame.
                        tx_sh       <= tx_head;
                        tx_par_bit  <= (^tx_head) ^ bus.Control[1];
                        tx_par_en   <= bus.Control[0];
                        tx_two_stop <= bus.Control[2];
                        tx_div      <= div_eff;
                        tx_cnt      <= div_eff;
                        tx_line     <= 1'b0;
                        tx_busy     <= 1'b1;
                        tx_state    <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_line  <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_bit   <= '0;
                        tx_cnt   <= tx_div;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= tx_div;
                        if (tx_bit == LAST_BIT) begin
                            if (tx_par_en) begin
                                tx_line  <= tx_par_bit;
                                tx_state <= S_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_stop2 <= 1'b0;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_line <= tx_sh[0];
                            tx_sh   <= tx_sh >> 1;
                            tx_bit  <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= tx_div;
                        tx_line  <= 1'b1;
                        tx_stop2 <= 1'b0;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == '0) begin
                        if (tx_two_stop && !tx_stop2) begin
                            tx_stop2 <= 1'b1;
                            tx_cnt   <= tx_div;
                        end else begin
                            tx_busy  <= 1'b0;
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX input path ----------------
    logic rx_sel, rx_meta, rx_sync, rx_prev;
    assign rx_sel = bus.Control[3] ? tx_line : bus.SLBit_in;

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_sel;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- RX FSM ----------------
    state_t            rx_state;
    logic [DIV_W-1:0]  rx_cnt, rx_div;
    logic [IDX_W-1:0]  rx_bit;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_par_en, rx_odd, rx_par_s;
    logic              rx_push, rx_par_bad, rx_frame_bad;

    // (div+1)/2 - 1 rewritten as (div-1)/2 to stay within DIV_W bits.
    logic [DIV_W-1:0] rx_half_m1;
    assign rx_half_m1 = (div_eff - 1'b1) >> 1;

    assign rx_push      = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_par_bad   = rx_push && rx_par_en && (rx_par_s != ((^rx_sh) ^ rx_odd));
    assign rx_frame_bad = rx_push && !rx_sync;

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_div    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            rx_par_s  <= 1'b0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_div    <= div_eff;
                        rx_par_en <= bus.Control[0];
                        rx_odd    <= bus.Control[1];
                        rx_cnt    <= rx_half_m1;
                        rx_state  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= rx_div;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= rx_div;
                        rx_sh  <= {rx_sync, rx_sh[DATA_W-1:1]};
                        if (rx_bit == LAST_BIT)
                            rx_state <= rx_par_en ? S_PARITY : S_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == '0) begin
                        rx_par_s <= rx_sync;
                        rx_cnt   <= rx_div;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == '0)
                        rx_state <= S_IDLE;
                    else
                        rx_cnt <= rx_cnt - 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0]  rx_count, rx_count_nxt;
    logic              rx_full, rx_empty;
    logic              rx_pop, rx_wr, rx_ovr;

    assign rx_pop = bus.Rd_En && !rx_empty;
    // A full FIFO still accepts the word when a pop frees a slot this cycle.
    assign rx_wr  = rx_push && (!rx_full || rx_pop);
    assign rx_ovr = rx_push && rx_full && !rx_pop;

    always_comb begin
        rx_count_nxt = rx_count;
        if (rx_wr && !rx_pop)
            rx_count_nxt = rx_count + 1'b1;
        else if (!rx_wr && rx_pop)
            rx_count_nxt = rx_count - 1'b1;
    end

    always_ff @(posedge CPU_Clk) begin
        if (rx_wr)
            rx_mem[rx_wr_ptr] <= rx_sh;
    end

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_full   <= 1'b0;
            rx_empty  <= 1'b1;
        end else begin
            if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count_nxt;
            rx_full  <= (rx_count_nxt == FULL_CNT);
            rx_empty <= (rx_count_nxt == '0);
        end
    end

    // ---------------- Sticky errors (set wins over clear) ----------------
    logic parity_err, frame_err, overrun;

    always_ff @(posedge CPU_Clk or negedge Reset) begin
        if (!Reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= rx_par_bad   | (parity_err & ~bus.Clr_Err);
            frame_err  <= rx_frame_bad | (frame_err  & ~bus.Clr_Err);
            overrun    <= rx_ovr       | (overrun    & ~bus.Clr_Err);
        end
    end

    // ---------------- Outputs ----------------
    assign bus.SLBit_out    = bus.Control[3] ? 1'b1 : tx_line;
    assign bus.CPU_Data_out = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    assign bus.Tx_Full      = tx_full;
    assign bus.Tx_Empty     = tx_empty;
    assign bus.Rx_Full      = rx_full;
    assign bus.Rx_Empty     = rx_empty;
    assign bus.Tx_Busy      = tx_busy;
    assign bus.Parity_Err   = parity_err;
    assign bus.Frame_Err    = frame_err;
    assign bus.Overrun      = overrun;
endmodule
